mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_pkg.sv | 26 ++
 rtl/rr_select.sv | 38 +++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory controller and its front-end arbiter:
// controller opcodes, arbiter state encoding and small helpers.
package mem_pkg;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b11
  } mem_op_e;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'b00,
    ARB_BUSY    = 2'b01,
    ARB_RELEASE = 2'b10
  } arb_state_e;

  // 2'b10 is reserved and never starts a transaction.
  function automatic logic is_xfer_op(input logic [1:0] op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: scans from ptr+1 upward, wrapping at N-1,
// and returns the first eligible entry as both one-hot and index.
module rr_select #(
  parameter int N  = 4,
  parameter int IW = mem_pkg::idx_width(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  winner_oh,
  output logic [IW-1:0] winner_idx,
  output logic          any
);

  // One spare bit so ptr + k (at most 2N-1) never overflows before wrapping.
  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  always_comb begin
    // NOTE: every variable written here gets a default first, otherwise paths
    // that skip an assignment would infer a latch.
    winner_oh  = '0;
    winner_idx = '0;
    any        = 1'b0;
    sum        = '0;
    cand       = '0;
    for (int k = 1; k <= N; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      cand = sum[IW-1:0];
      if (!any && eligible[cand]) begin
        any             = 1'b1;
        winner_oh[cand] = 1'b1;
        winner_idx      = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory controller among NUM_REQ requesters;
// the winner's command is captured at grant time and held for the transaction.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int ADDR_BITCOUNT = 64,
  parameter int WORD_SIZE     = 512
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_REQ-1:0]                     req,
  input  logic [NUM_REQ-1:0][1:0]                req_op,
  input  logic [NUM_REQ-1:0][ADDR_BITCOUNT-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][WORD_SIZE-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]                     grant,
  output logic [NUM_REQ-1:0]                     req_done,
  output logic [NUM_REQ-1:0]                     req_rd_valid,
  output logic [WORD_SIZE-1:0]                   req_rdata,
  input  logic                                   mem_ready,
  input  logic                                   mem_tx_done,
  input  logic                                   mem_rd_valid,
  input  logic [WORD_SIZE-1:0]                   mem_rdata,
  output logic [1:0]                             mem_op,
  output logic [ADDR_BITCOUNT-1:0]               mem_addr,
  output logic [WORD_SIZE-1:0]                   mem_wdata,
  output logic                                   busy
);

  localparam int IW = idx_width(NUM_REQ);

  arb_state_e               state_q, state_d;
  logic [IW-1:0]            last_grant_q;
  logic [IW-1:0]            owner_q;
  logic [NUM_REQ-1:0]       grant_q;
  logic [1:0]               op_q;
  logic [ADDR_BITCOUNT-1:0] addr_q;
  logic [WORD_SIZE-1:0]     wdata_q;

  logic [NUM_REQ-1:0]       eligible;
  logic [NUM_REQ-1:0]       win_oh;
  logic [IW-1:0]            win_idx;
  logic                     win_any;
  logic                     start;

  // A stalled controller (mem_ready low) masks every requester.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req[i] && is_xfer_op(req_op[i]) && mem_ready;
    end
  end

  rr_select #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_select (
    .eligible   (eligible),
    .ptr        (last_grant_q),
    .winner_oh  (win_oh),
    .winner_idx (win_idx),
    .any        (win_any)
  );

  assign start = (state_q == ARB_IDLE) && win_any;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values regardless of process ordering.
    if (!rst_n) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:    if (win_any)     state_d = ARB_BUSY;
      ARB_BUSY:    if (mem_tx_done) state_d = ARB_RELEASE;
      ARB_RELEASE:                  state_d = ARB_IDLE;
      default:                      state_d = ARB_IDLE;
    endcase
  end

  // Command capture. The pointer starts at NUM_REQ-1 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the captured command drives mem_addr/mem_wdata directly, so it is
      // reset to keep those outputs at zero while rst_n is low.
      last_grant_q <= IW'(NUM_REQ - 1);
      owner_q      <= '0;
      grant_q      <= '0;
      op_q         <= OP_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else if (start) begin
      last_grant_q <= win_idx;
      owner_q      <= win_idx;
      grant_q      <= win_oh;
      op_q         <= req_op[win_idx];
      addr_q       <= req_addr[win_idx];
      wdata_q      <= req_wdata[win_idx];
    end
  end

  // Controller strobes are only meaningful while a transaction is in flight.
  always_comb begin
    grant        = '0;
    req_done     = '0;
    req_rd_valid = '0;
    mem_op       = OP_IDLE;
    if (state_q == ARB_BUSY) begin
      grant                 = grant_q;
      mem_op                = op_q;
      req_done[owner_q]     = mem_tx_done;
      req_rd_valid[owner_q] = mem_rd_valid;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign req_rdata = mem_rdata;
  assign busy      = (state_q != ARB_IDLE);

  a_grant_onehot: assert property (
    @(posedge clk) disable iff (!rst_n) $onehot0(grant));

  a_release_one_cycle: assert property (
    @(posedge clk) disable iff (!rst_n) state_q == ARB_RELEASE |=> state_q == ARB_IDLE);

  a_busy_holds_cmd: assert property (
    @(posedge clk) disable iff (!rst_n)
    (state_q == ARB_BUSY) && !mem_tx_done |=> $stable(mem_addr) && $stable(mem_op) && $stable(mem_wdata));

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: the driver predicts each grant
// and completion from the arbitration rules; a monitor pops and compares.
module tb_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int DW = 512;

  typedef struct {
    logic [N-1:0]  grant;
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  typedef struct {
    int            cycle;
    logic [N-1:0]  vec;
    logic [DW-1:0] data;
  } pulse_t;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [N-1:0]            req;
  logic [N-1:0][1:0]       req_op;
  logic [N-1:0][AW-1:0]    req_addr;
  logic [N-1:0][DW-1:0]    req_wdata;
  logic [N-1:0]            grant;
  logic [N-1:0]            req_done;
  logic [N-1:0]            req_rd_valid;
  logic [DW-1:0]           req_rdata;
  logic                    mem_ready;
  logic                    mem_tx_done;
  logic                    mem_rd_valid;
  logic [DW-1:0]           mem_rdata;
  logic [1:0]              mem_op;
  logic [AW-1:0]           mem_addr;
  logic [DW-1:0]           mem_wdata;
  logic                    busy;

  mem_arbiter #(
    .NUM_REQ       (N),
    .ADDR_BITCOUNT (AW),
    .WORD_SIZE     (DW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .grant        (grant),
    .req_done     (req_done),
    .req_rd_valid (req_rd_valid),
    .req_rdata    (req_rdata),
    .mem_ready    (mem_ready),
    .mem_tx_done  (mem_tx_done),
    .mem_rd_valid (mem_rd_valid),
    .mem_rdata    (mem_rdata),
    .mem_op       (mem_op),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  txn_t   exp_q[$];
  pulse_t done_q[$];
  pulse_t rd_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     phase = 0;      // expected arbiter phase: 0 idle, 1 busy, 2 release
  int     last_m = N - 1; // model's most recently granted requester

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [DW-1:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0h expected nothing at t=%0t", name, act, $time);
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    w = '0;
    for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    return {$urandom, $urandom};
  endfunction

  // Reference arbitration: the first requester with a read/write op, counting
  // upward from the one after the previous winner and wrapping around.
  function automatic int model_pick(input logic [N-1:0] r, input logic [N-1:0][1:0] ops,
                                    input logic ready, input int last);
    if (!ready) return -1;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (r[i] && (ops[i] == 2'b01 || ops[i] == 2'b11)) return i;
    end
    return -1;
  endfunction

  task automatic randomize_inputs();
    req = N'($urandom);
    for (int i = 0; i < N; i++) begin
      req_op[i]    = 2'($urandom);
      req_addr[i]  = rand_addr();
      req_wdata[i] = rand_word();
    end
  endtask

  task automatic issue(output int w);
    txn_t t;
    w = model_pick(req, req_op, mem_ready, last_m);
    if (w >= 0) begin
      t.grant    = '0;
      t.grant[w] = 1'b1;
      t.op       = req_op[w];
      t.addr     = req_addr[w];
      t.wdata    = req_wdata[w];
      exp_q.push_back(t);
      last_m = w;
    end
  endtask

  // Called at a negedge while the arbiter is idle, with req* already driven.
  task automatic run_txn(input bit scramble, input bit hold, input int ready_delay, input bit force_rd);
    int           w;
    int           n_busy;
    logic [N-1:0] own_oh;
    phase = 0;
    if (ready_delay > 0) begin
      mem_ready = 1'b0;
      repeat (ready_delay) @(negedge clk);
    end
    mem_ready = 1'b1;
    issue(w);
    if (w < 0) begin
      @(negedge clk);
      return;
    end
    own_oh    = '0;
    own_oh[w] = 1'b1;
    @(negedge clk);
    phase = 1;
    if (scramble) begin
      randomize_inputs();
      req[w]      = 1'b0;
      req_addr[w] = rand_addr();
    end
    n_busy = $urandom_range(0, 3);
    if (force_rd && n_busy == 0) n_busy = 1;
    for (int k = 0; k < n_busy; k++) begin
      mem_ready = 1'($urandom_range(0, 1));
      if ((force_rd && k == 0) || $urandom_range(0, 1) == 1) begin
        mem_rd_valid = 1'b1;
        mem_rdata    = rand_word();
        rd_q.push_back('{cycle: cyc, vec: own_oh, data: mem_rdata});
      end
      @(negedge clk);
      mem_rd_valid = 1'b0;
    end
    mem_ready   = 1'b1;
    mem_tx_done = 1'b1;
    done_q.push_back('{cycle: cyc, vec: own_oh, data: '0});
    @(negedge clk);
    phase        = 2;
    mem_tx_done  = 1'($urandom_range(0, 1));
    mem_rd_valid = 1'($urandom_range(0, 1));
    if (!hold) req = '0;
    @(negedge clk);
    phase        = 0;
    mem_tx_done  = 1'b0;
    mem_rd_valid = 1'b0;
  endtask

  task automatic idle_noise();
    req          = '0;
    phase        = 0;
    mem_tx_done  = 1'b1;
    mem_rd_valid = 1'b1;
    mem_rdata    = rand_word();
    @(negedge clk);
    mem_tx_done  = 1'b0;
    mem_rd_valid = 1'b0;
  endtask

  task automatic reset_mid_busy();
    int w;
    req          = '0;
    req[3]       = 1'b1;
    req_op[3]    = 2'b11;
    req_addr[3]  = rand_addr();
    req_wdata[3] = rand_word();
    issue(w);
    @(negedge clk);
    phase = 1;
    @(negedge clk);
    rst_n        = 1'b0;
    phase        = 0;
    mem_tx_done  = 1'b1;
    mem_rd_valid = 1'b1;
    repeat (2) @(negedge clk);
    mem_tx_done  = 1'b0;
    mem_rd_valid = 1'b0;
    last_m       = N - 1;
    rst_n        = 1'b1;
  endtask

  initial begin : monitor
    txn_t         cur;
    pulse_t       p;
    logic [N-1:0] prev_grant;
    prev_grant = '0;
    cur        = '{default: '0};
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        check("rst_grant", DW'(grant), '0);
        check("rst_req_done", DW'(req_done), '0);
        check("rst_req_rd_valid", DW'(req_rd_valid), '0);
        check("rst_mem_op", DW'(mem_op), '0);
        check("rst_mem_addr", DW'(mem_addr), '0);
        check("rst_mem_wdata", mem_wdata, '0);
        check("rst_busy", DW'(busy), '0);
      end else begin
        if (grant != '0 && prev_grant == '0) begin
          if (exp_q.size() == 0) unexpected("unexpected_grant", DW'(grant));
          else cur = exp_q.pop_front();
        end
        if (phase == 1) begin
          check("grant", DW'(grant), DW'(cur.grant));
          check("mem_op", DW'(mem_op), DW'(cur.op));
          check("mem_addr", DW'(mem_addr), DW'(cur.addr));
          check("mem_wdata", mem_wdata, cur.wdata);
        end else begin
          check("idle_grant", DW'(grant), '0);
          check("idle_mem_op", DW'(mem_op), '0);
        end
        check("busy", DW'(busy), DW'(phase != 0));
        if (req_done != '0) begin
          if (done_q.size() == 0) unexpected("unexpected_req_done", DW'(req_done));
          else begin
            p = done_q.pop_front();
            check("req_done", DW'(req_done), DW'(p.vec));
            check("req_done_cycle", DW'(cyc), DW'(p.cycle));
          end
        end
        if (req_rd_valid != '0) begin
          if (rd_q.size() == 0) unexpected("unexpected_req_rd_valid", DW'(req_rd_valid));
          else begin
            p = rd_q.pop_front();
            check("req_rd_valid", DW'(req_rd_valid), DW'(p.vec));
            check("req_rd_valid_cycle", DW'(cyc), DW'(p.cycle));
            check("req_rdata", req_rdata, p.data);
          end
        end
      end
      prev_grant = grant;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    req          = '0;
    req_op       = '0;
    req_addr     = '0;
    req_wdata    = '0;
    mem_ready    = 1'b1;
    mem_tx_done  = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rdata    = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single read from requester 0 at address 0x40.
    req          = 4'b0001;
    req_op[0]    = 2'b01;
    req_addr[0]  = 64'h40;
    req_wdata[0] = rand_word();
    run_txn(1'b0, 1'b0, 0, 1'b1);

    // Controller not ready: no grant until mem_ready rises.
    req          = 4'b0010;
    req_op[1]    = 2'b01;
    req_addr[1]  = rand_addr();
    run_txn(1'b0, 1'b0, 6, 1'b0);

    // Owner drops req and changes its address mid-transaction.
    req          = 4'b0100;
    req_op[2]    = 2'b11;
    req_addr[2]  = rand_addr();
    req_wdata[2] = rand_word();
    run_txn(1'b1, 1'b0, 0, 1'b0);

    // Reset during a transaction, then all four requesters writing, held.
    reset_mid_busy();
    req = '1;
    for (int i = 0; i < N; i++) begin
      req_op[i]    = 2'b11;
      req_addr[i]  = rand_addr();
      req_wdata[i] = rand_word();
    end
    repeat (5) run_txn(1'b0, 1'b1, 0, 1'b0);

    // Idle and reserved opcodes are never granted.
    req    = '1;
    req_op = {2'b10, 2'b00, 2'b10, 2'b00};
    run_txn(1'b0, 1'b0, 0, 1'b0);
    idle_noise();

    repeat (200) begin
      if ($urandom_range(0, 3) == 0) idle_noise();
      randomize_inputs();
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0,
              1'($urandom_range(0, 1)));
    end

    req = '0;
    repeat (3) @(negedge clk);
    check("pending_grants", DW'(exp_q.size()), '0);
    check("pending_req_done", DW'(done_q.size()), '0);
    check("pending_req_rd_valid", DW'(rd_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
